// File: rtl/mem_responder.sv
// Dual-port word memory behind two independent request/response handshakes with fixed latency.
// The inst port is read-only; the data port reads or byte-merges writes, committed at its response.
module mem_responder #(
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_read,
   input  logic [31:0] inst_addr,
   output logic        inst_resp,
   output logic [31:0] inst_rdata,
   input  logic        data_read,
   input  logic        data_write,
   input  logic [3:0]  data_mbe,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_resp,
   output logic [31:0] data_rdata,
   output logic        proto_err
);

   localparam int unsigned Depth   = 2 ** DEPTH_LOG2;
   localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   logic [31:0] mem_q [Depth];

   state_e                inst_state_q, inst_state_d;
   logic [3:0]            inst_cnt_q, inst_cnt_d;
   logic [DEPTH_LOG2-1:0] inst_idx_q, inst_idx_d;

   state_e                data_state_q, data_state_d;
   logic [3:0]            data_cnt_q, data_cnt_d;
   logic [DEPTH_LOG2-1:0] data_idx_q, data_idx_d;
   logic [3:0]            data_mbe_q, data_mbe_d;
   logic [31:0]           data_wdata_q, data_wdata_d;
   logic                  data_wr_q, data_wr_d;
   logic                  proto_q, proto_d;

   logic                  data_commit;
   logic [31:0]           data_merged;

   // Address bits outside the word index are deliberately dropped (wrap modulo depth).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{inst_addr[31:DEPTH_LOG2+2], inst_addr[1:0],
                               data_addr[31:DEPTH_LOG2+2], data_addr[1:0]};

   // ---------------- inst port ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_state_q <= StIdle;
         inst_cnt_q   <= '0;
         inst_idx_q   <= '0;
      end else begin
         inst_state_q <= inst_state_d;
         inst_cnt_q   <= inst_cnt_d;
         inst_idx_q   <= inst_idx_d;
      end
   end

   always_comb begin
      inst_state_d = inst_state_q;
      inst_cnt_d   = inst_cnt_q;
      inst_idx_d   = inst_idx_q;
      unique case (inst_state_q)
         StIdle: begin
            if (inst_read) begin
               inst_idx_d   = inst_addr[DEPTH_LOG2+1:2];
               inst_cnt_d   = CntInit;
               inst_state_d = (LATENCY == 1) ? StResp : StBusy;
            end
         end
         StBusy: begin
            inst_cnt_d = inst_cnt_q - 4'd1;
            if (inst_cnt_q <= 4'd1) begin
               inst_state_d = StResp;
            end
         end
         StResp:  inst_state_d = StIdle;
         default: inst_state_d = StIdle;
      endcase
   end

   always_comb begin
      inst_resp  = 1'b0;
      inst_rdata = 32'h0;
      if (inst_state_q == StResp) begin
         inst_resp  = 1'b1;
         inst_rdata = mem_q[inst_idx_q];
      end
   end

   // ---------------- data port ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         data_state_q <= StIdle;
         data_cnt_q   <= '0;
         data_idx_q   <= '0;
         data_mbe_q   <= '0;
         data_wdata_q <= '0;
         data_wr_q    <= 1'b0;
         proto_q      <= 1'b0;
      end else begin
         data_state_q <= data_state_d;
         data_cnt_q   <= data_cnt_d;
         data_idx_q   <= data_idx_d;
         data_mbe_q   <= data_mbe_d;
         data_wdata_q <= data_wdata_d;
         data_wr_q    <= data_wr_d;
         proto_q      <= proto_d;
      end
   end

   always_comb begin
      data_state_d = data_state_q;
      data_cnt_d   = data_cnt_q;
      data_idx_d   = data_idx_q;
      data_mbe_d   = data_mbe_q;
      data_wdata_d = data_wdata_q;
      data_wr_d    = data_wr_q;
      proto_d      = proto_q;
      unique case (data_state_q)
         StIdle: begin
            if (data_read || data_write) begin
               data_idx_d   = data_addr[DEPTH_LOG2+1:2];
               data_mbe_d   = data_mbe;
               data_wdata_d = data_wdata;
               // A simultaneous read+write is treated as a write and flagged.
               data_wr_d    = data_write;
               proto_d      = proto_q | (data_read & data_write);
               data_cnt_d   = CntInit;
               data_state_d = (LATENCY == 1) ? StResp : StBusy;
            end
         end
         StBusy: begin
            data_cnt_d = data_cnt_q - 4'd1;
            if (data_cnt_q <= 4'd1) begin
               data_state_d = StResp;
            end
         end
         StResp:  data_state_d = StIdle;
         default: data_state_d = StIdle;
      endcase
   end

   always_comb begin
      data_resp   = 1'b0;
      data_rdata  = 32'h0;
      data_commit = 1'b0;
      data_merged = mem_q[data_idx_q];
      for (int b = 0; b < 4; b++) begin
         if (data_mbe_q[b]) begin
            data_merged[8*b +: 8] = data_wdata_q[8*b +: 8];
         end
      end
      if (data_state_q == StResp) begin
         data_resp   = 1'b1;
         data_rdata  = mem_q[data_idx_q];
         data_commit = data_wr_q;
      end
   end

   assign proto_err = proto_q;

   // ---------------- storage ----------------
   // Commit happens on the edge closing RESP, so a same-cycle inst read sees the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= 32'h0;
         end
      end else if (data_commit) begin
         mem_q[data_idx_q] <= data_merged;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked every cycle against an accept-edge/latency arithmetic model.
module tb_mem_responder;

   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_read;
   logic [31:0] inst_addr;
   logic        inst_resp;
   logic [31:0] inst_rdata;
   logic        data_read;
   logic        data_write;
   logic [3:0]  data_mbe;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_resp;
   logic [31:0] data_rdata;
   logic        proto_err;

   mem_responder #(
      .LATENCY    (L),
      .DEPTH_LOG2 (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .inst_read  (inst_read),
      .inst_addr  (inst_addr),
      .inst_resp  (inst_resp),
      .inst_rdata (inst_rdata),
      .data_read  (data_read),
      .data_write (data_write),
      .data_mbe   (data_mbe),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .data_resp  (data_resp),
      .data_rdata (data_rdata),
      .proto_err  (proto_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A request accepted on edge a responds in the cycle after edge a+L-1, its write lands
   // on edge a+L, and the port may next accept on edge a+L+1.
   logic [31:0] ref_mem [256];
   int          edge_n = 0;
   int          i_acc, d_acc, i_free, d_free;
   logic [7:0]  i_idx, d_idx;
   logic [3:0]  d_mbe;
   logic [31:0] d_wd;
   logic        d_wr;
   logic        exp_proto = 1'b0;
   logic        exp_iresp = 1'b0, exp_dresp = 1'b0;
   logic [31:0] exp_irdata = '0, exp_drdata = '0;
   logic        model_ok = 1'b0;

   initial begin
      i_acc = -1;
      d_acc = -1;
      forever begin
         @(posedge clk);
         edge_n++;
         if (rst) begin
            for (int k = 0; k < 256; k++) ref_mem[k] = 32'h0;
            i_acc     = -1;
            d_acc     = -1;
            i_free    = edge_n + 1;
            d_free    = edge_n + 1;
            exp_proto = 1'b0;
            model_ok  = 1'b1;
         end else begin
            if (d_acc >= 0 && edge_n == d_acc + L) begin
               if (d_wr) begin
                  for (int b = 0; b < 4; b++)
                     if (d_mbe[b]) ref_mem[d_idx][8*b +: 8] = d_wd[8*b +: 8];
               end
               d_acc = -1;
            end
            if (i_acc >= 0 && edge_n == i_acc + L) i_acc = -1;
            if (i_acc < 0 && edge_n >= i_free && inst_read) begin
               i_acc  = edge_n;
               i_idx  = inst_addr[9:2];
               i_free = edge_n + L + 1;
            end
            if (d_acc < 0 && edge_n >= d_free && (data_read || data_write)) begin
               d_acc  = edge_n;
               d_idx  = data_addr[9:2];
               d_mbe  = data_mbe;
               d_wd   = data_wdata;
               d_wr   = data_write;
               d_free = edge_n + L + 1;
               if (data_read && data_write) exp_proto = 1'b1;
            end
         end
         exp_iresp  = (i_acc >= 0 && edge_n == i_acc + L - 1);
         exp_irdata = exp_iresp ? ref_mem[i_idx] : 32'h0;
         exp_dresp  = (d_acc >= 0 && edge_n == d_acc + L - 1);
         exp_drdata = exp_dresp ? ref_mem[d_idx] : 32'h0;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_ok) begin
            check("inst_resp", 32'(inst_resp), 32'(exp_iresp));
            check("inst_rdata", inst_rdata, exp_irdata);
            check("data_resp", 32'(data_resp), 32'(exp_dresp));
            check("data_rdata", data_rdata, exp_drdata);
            check("proto_err", 32'(proto_err), 32'(exp_proto));
         end
      end
   end

   // ---------------- transaction helpers ----------------
   task automatic data_txn(input logic rd, input logic wr, input logic [3:0] mbe,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output int lat);
      @(posedge clk); #1;
      data_read = rd; data_write = wr; data_mbe = mbe; data_addr = addr; data_wdata = wd;
      @(posedge clk); #1;
      // Scramble captured fields after acceptance; the response must not follow them.
      data_read = 1'b0; data_write = 1'b0;
      data_addr = $urandom; data_wdata = $urandom; data_mbe = 4'($urandom);
      lat   = 1;
      rdata = 32'h0;
      for (int i = 0; i < 20; i++) begin
         if (data_resp) begin
            rdata = data_rdata;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic inst_txn(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
      @(posedge clk); #1;
      inst_read = 1'b1; inst_addr = addr;
      @(posedge clk); #1;
      inst_read = 1'b0; inst_addr = $urandom;
      lat   = 1;
      rdata = 32'h0;
      for (int i = 0; i < 20; i++) begin
         if (inst_resp) begin
            rdata = inst_rdata;
            break;
         end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   logic [31:0] rd, rd2;
   int          lat, lat2;
   int          last_i, pulse_cnt;

   initial begin
      rst = 1'b1;
      inst_read = 1'b0; inst_addr = '0;
      data_read = 1'b0; data_write = 1'b0; data_mbe = '0; data_addr = '0; data_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_inst_resp", 32'(inst_resp), 32'h0);
      check("rst_data_resp", 32'(data_resp), 32'h0);
      check("rst_proto_err", 32'(proto_err), 32'h0);
      rst = 1'b0;

      // Basic write then read back.
      data_txn(1'b0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, lat);
      check("wr_latency", 32'(lat), 32'd2);
      check("wr_prewrite_data", rd, 32'h0);
      data_txn(1'b1, 1'b0, 4'hF, 32'h10, 32'h0, rd, lat);
      check("rd_latency", 32'(lat), 32'd2);
      check("rd_data", rd, 32'hDEADBEEF);

      // Byte-enable merge and empty mask.
      data_txn(1'b0, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, lat);
      data_txn(1'b0, 1'b1, 4'b0100, 32'h20, 32'h00AB0000, rd, lat);
      data_txn(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, rd, lat);
      check("mbe_merge", rd, 32'h11AB3344);
      data_txn(1'b0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, rd, lat);
      check("mbe_zero_prewrite", rd, 32'h11AB3344);
      data_txn(1'b1, 1'b0, 4'hF, 32'h20, 32'h0, rd, lat);
      check("mbe_zero_unchanged", rd, 32'h11AB3344);

      // Same-word collision: inst read in lockstep with data write sees the old word.
      data_txn(1'b0, 1'b1, 4'hF, 32'h40, 32'h1, rd, lat);
      fork
         inst_txn(32'h40, rd, lat);
         data_txn(1'b0, 1'b1, 4'hF, 32'h40, 32'h2, rd2, lat2);
      join
      check("collision_old", rd, 32'h1);
      check("collision_lat", 32'(lat), 32'd2);
      inst_txn(32'h40, rd, lat);
      check("collision_new", rd, 32'h2);

      // Read+write conflict, address wrap.
      data_txn(1'b1, 1'b1, 4'hF, 32'h408, 32'h55, rd, lat);
      check("proto_set", 32'(proto_err), 32'h1);
      data_txn(1'b1, 1'b0, 4'hF, 32'h008, 32'h0, rd, lat);
      check("wrap_alias", rd, 32'h55);
      repeat (5) @(posedge clk);
      #1;
      check("proto_sticky", 32'(proto_err), 32'h1);

      // Reset while a write is in BUSY.
      @(posedge clk); #1;
      data_write = 1'b1; data_mbe = 4'hF; data_addr = 32'h30; data_wdata = 32'h77;
      @(posedge clk); #1;
      data_write = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("abort_no_resp", 32'(data_resp), 32'h0);
         check("abort_proto_clr", 32'(proto_err), 32'h0);
         @(posedge clk); #1;
      end
      data_txn(1'b1, 1'b0, 4'hF, 32'h30, 32'h0, rd, lat);
      check("abort_no_commit", rd, 32'h0);

      // Continuous inst requests alongside an independent data read.
      last_i = 0;
      pulse_cnt = 0;
      fork
         begin
            @(posedge clk); #1;
            inst_read = 1'b1; inst_addr = 32'h40;
            for (int i = 1; i <= 12; i++) begin
               @(posedge clk); #1;
               if (inst_resp) begin
                  if (pulse_cnt > 0) check("cont_period", 32'(i - last_i), 32'd3);
                  last_i = i;
                  pulse_cnt++;
               end
            end
            inst_read = 1'b0;
         end
         begin
            data_txn(1'b1, 1'b0, 4'hF, 32'h30, 32'h0, rd2, lat2);
         end
      join
      check("cont_pulses", 32'(pulse_cnt), 32'd4);
      check("cont_data_lat", 32'(lat2), 32'd2);
      repeat (4) @(posedge clk);

      // Randomized traffic over a small address window (with aliasing upper bits).
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         rst        = ($urandom_range(0, 99) == 0);
         inst_read  = 1'($urandom_range(0, 1));
         inst_addr  = $urandom & ~32'h3C0;
         data_read  = ($urandom_range(0, 2) == 0);
         data_write = ($urandom_range(0, 2) == 0);
         data_mbe   = 4'($urandom);
         data_addr  = $urandom & ~32'h3C0;
         data_wdata = $urandom;
      end
      @(posedge clk); #1;
      rst = 1'b0; inst_read = 1'b0; data_read = 1'b0; data_write = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
